n2_irq_sched: RTL
=================

N2_IRQ_SCHED -- requirements
Module: n2_irq_sched

Interface
REQ-001 Parameter NUM_IRQ, default 31: number of interrupt lines, ids 1..NUM_IRQ; id 0 means "no request".
REQ-002 clk  input  1  core clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 irq_i  input  32  interrupt event pulses; bit n = id n; bit 0 ignored.
REQ-005 mask_we_i  input  1  write strobe for mask register.
REQ-006 mask_wdata_i  input  32  new mask value; 1 = line masked; bit 0 ignored.
REQ-007 mask_o  output  32  current mask register.
REQ-008 pending_o  output  32  current pending vector.
REQ-009 irq_offset_o  output  5  offered id to decode stage; 0 = none.
REQ-010 irq_ack_i  input  1  decode accepted the offered interrupt.
REQ-011 irq_id_i  input  5  id accepted by decode, valid with irq_ack_i.
REQ-012 irq_processing_o  output  1  handler in service.
REQ-013 retirq_i  input  1  handler return (retirq retired).
REQ-014 ack_err_o  output  1  sticky flag: ack protocol violation.
REQ-015 irq_count_o  output  32  number of accepted interrupts.

Function
REQ-016 All outputs SHALL be registered.
REQ-017 pending[n] SHALL be set the cycle after irq_i[n]=1; cleared only by an accepted ack of id n.
REQ-018 A pulse on line n in the same cycle as an ack of id n SHALL leave pending[n]=1.
REQ-019 Masking SHALL NOT clear pending bits; it only excludes them from arbitration.
REQ-020 mask_we_i SHALL update mask_o on the next edge; bit 0 always reads 0.
REQ-021 FSM states: IDLE, REQ, SERVICE.
REQ-022 IDLE: irq_offset_o=0, irq_processing_o=0; if any pending & ~mask bit exists, go to REQ and load irq_offset_o with the round-robin winner on the same edge.
REQ-023 Round-robin: search starts at last_grant+1, ascending, wraps NUM_IRQ→1; last_grant updates to the id on each accepted ack.
REQ-024 REQ: irq_offset_o SHALL hold stable until ack or withdrawal.
REQ-025 REQ withdrawal: if the offered line becomes masked (mask_o bit set), next state IDLE and irq_offset_o=0; re-arbitration waits one IDLE cycle.
REQ-026 REQ + irq_ack_i: next state SERVICE, irq_offset_o=0, irq_processing_o=1, pending[irq_id_i] cleared, irq_count_o incremented (wraps 2^32-1→0).
REQ-027 Ack with irq_id_i != irq_offset_o SHALL set ack_err_o and still clear pending[irq_offset_o] and enter SERVICE.
REQ-028 irq_ack_i in IDLE or SERVICE SHALL set ack_err_o and have no other effect.
REQ-029 SERVICE: irq_offset_o=0; no nesting; new events only pend; retirq_i → IDLE with irq_processing_o=0 on the next edge.
REQ-030 retirq_i in IDLE or REQ SHALL be ignored (no error).
REQ-031 Minimum latency: pulse at edge t → pending at t+1 → irq_offset_o nonzero at t+2.
REQ-032 Simultaneous retirq_i and new pending in SERVICE: go to IDLE first; offer no earlier than the following edge.

Reset
REQ-033 rst=1 SHALL force: state IDLE, pending=0, mask_o=0, irq_offset_o=0, irq_processing_o=0, ack_err_o=0, irq_count_o=0, last_grant=NUM_IRQ (first search starts at id 1).
REQ-034 Reset mid-REQ or mid-SERVICE SHALL discard the in-flight interrupt with no ack or count.
REQ-035 Events on irq_i during rst SHALL be dropped.

Verification
REQ-036 Single: pulse irq_i[5] at t → irq_offset_o=5 at t+2; ack id 5 → irq_processing_o=1, pending_o[5]=0, irq_count_o=1; retirq_i → IDLE.
REQ-037 Round-robin: pend ids 3,7,12 together, then ack/retirq repeatedly → grant order 3,7,12; re-pend 3 and 12 after granting 7 → order 12 then 3.
REQ-038 Mask: pend 4 with mask bit 4 set → irq_offset_o stays 0; clear mask → offset 4; mask during REQ → offset 0 next cycle, pending_o[4] stays 1.
REQ-039 Errors: ack id 9 while offering 6 → ack_err_o=1, pending_o[6]=0, SERVICE; ack in IDLE → ack_err_o=1, count unchanged.
REQ-040 Collisions: pulse irq_i[2] in the ack cycle of id 2 → pending_o[2]=1 afterwards; retirq with pending 8 → IDLE one cycle, then offer 8.
REQ-041 Reset in SERVICE with pending 0x0000_0110 → all outputs zero next cycle, pending_o=0, no offer afterwards.

Source files
------------

// File: rtl/n2_irq_sched.sv
// Interrupt scheduler: latches event pulses into a pending vector and offers one
// unmasked line at a time to the decode stage, round-robin, with no nesting.
module n2_irq_sched #(
  parameter int NUM_IRQ = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] irq_i,
  input  logic        mask_we_i,
  input  logic [31:0] mask_wdata_i,
  output logic [31:0] mask_o,
  output logic [31:0] pending_o,
  output logic [4:0]  irq_offset_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_id_i,
  output logic        irq_processing_o,
  input  logic        retirq_i,
  output logic        ack_err_o,
  output logic [31:0] irq_count_o
);

  // Lines 1..NUM_IRQ exist; bit 0 and anything above are tied off.
  localparam logic [31:0] LINE_MASK =
    ((NUM_IRQ >= 31) ? 32'hFFFF_FFFF : ((32'd1 << (NUM_IRQ + 1)) - 32'd1)) & ~32'd1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_SERVICE} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [31:0] mask_q, mask_d;
  logic [4:0]  offset_q, offset_d;
  logic        proc_q, proc_d;
  logic        err_q, err_d;
  logic [31:0] count_q, count_d;
  logic [4:0]  last_q, last_d;

  logic [31:0] elig;
  logic [31:0] clr;
  logic        found;
  logic [4:0]  win;
  logic [5:0]  cand;

  assign elig = pending_q & ~mask_q;

  // Round-robin: first eligible id strictly after last_q, wrapping NUM_IRQ -> 1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_IRQ; k++) begin
      cand = {1'b0, last_q} + 6'(k);
      if (cand > 6'(NUM_IRQ)) cand = cand - 6'(NUM_IRQ);
      if (!found && elig[cand[4:0]]) begin
        found = 1'b1;
        win   = cand[4:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    proc_d   = proc_q;
    err_d    = err_q;
    count_d  = count_q;
    last_d   = last_q;
    clr      = '0;
    case (state_q)
      S_IDLE: begin
        offset_d = '0;
        proc_d   = 1'b0;
        if (irq_ack_i) err_d = 1'b1;
        if (found) begin
          state_d  = S_REQ;
          offset_d = win;
        end
      end
      S_REQ: begin
        // An ack retires the offered line even if decode reports a different id.
        if (irq_ack_i) begin
          state_d       = S_SERVICE;
          offset_d      = '0;
          proc_d        = 1'b1;
          clr[offset_q] = 1'b1;
          count_d       = count_q + 32'd1;
          last_d        = offset_q;
          if (irq_id_i != offset_q) err_d = 1'b1;
        end else if (mask_q[offset_q]) begin
          state_d  = S_IDLE;
          offset_d = '0;
        end
      end
      S_SERVICE: begin
        offset_d = '0;
        if (irq_ack_i) err_d = 1'b1;
        if (retirq_i) begin
          state_d = S_IDLE;
          proc_d  = 1'b0;
        end
      end
      default: begin
        state_d  = S_IDLE;
        offset_d = '0;
        proc_d   = 1'b0;
      end
    endcase
  end

  // A new pulse wins over a same-cycle clear so the event is not lost.
  assign pending_d = ((pending_q & ~clr) | irq_i) & LINE_MASK;
  assign mask_d    = mask_we_i ? (mask_wdata_i & LINE_MASK) : mask_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      offset_q  <= '0;
      proc_q    <= 1'b0;
      err_q     <= 1'b0;
      count_q   <= '0;
      last_q    <= 5'(NUM_IRQ);
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      offset_q  <= offset_d;
      proc_q    <= proc_d;
      err_q     <= err_d;
      count_q   <= count_d;
      last_q    <= last_d;
    end
  end

  assign mask_o           = mask_q;
  assign pending_o        = pending_q;
  assign irq_offset_o     = offset_q;
  assign irq_processing_o = proc_q;
  assign ack_err_o        = err_q;
  assign irq_count_o      = count_q;

endmodule
